// File: rtl/ttt_turn_sequencer.sv
// Turn/round controller in front of the tic_tac_toe_game core: arbitrates and validates
// moves, strobes them into the core, samples its result and keeps match score.
module ttt_turn_sequencer #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int WIN_TARGET     = 3,
    parameter int SCORE_W        = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               first_pc,
    input  logic               player_req,
    input  logic [3:0]         player_pos,
    output logic               player_ack,
    output logic               player_err,
    input  logic               computer_req,
    input  logic [3:0]         computer_pos,
    output logic               computer_ack,
    output logic               computer_err,
    input  logic [1:0]         who,
    output logic               play,
    output logic               pc,
    output logic [3:0]         player_position,
    output logic [3:0]         computer_position,
    output logic               core_clear,
    output logic               turn,
    output logic [3:0]         move_count,
    output logic               round_done,
    output logic [1:0]         round_result,
    output logic [SCORE_W-1:0] player_score,
    output logic [SCORE_W-1:0] computer_score,
    output logic               match_over
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TW-1:0]      TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0]      SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] TARGET       = SCORE_W'(WIN_TARGET);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT, S_ISSUE, S_SETTLE, S_ROUND_END, S_MATCH_OVER
    } state_t;

    state_t          state, state_next;
    logic            round_starter;
    logic [8:0]      mask;
    logic [TW-1:0]   wait_cnt;
    logic [SW-1:0]   settle_cnt;
    logic [1:0]      end_result;
    logic            req_sel;
    logic [3:0]      pos_sel;
    logic            pos_ok;
    logic            accept;

    function automatic logic [8:0] cell_bit(input logic [3:0] p);
        return 9'b1 << p;
    endfunction

    // Shift-based lookup keeps out-of-range cells (9..15) from indexing past the mask.
    function automatic logic cell_free(input logic [8:0] m, input logic [3:0] p);
        return (p <= 4'd8) && ((m & cell_bit(p)) == 9'b0);
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign req_sel = turn ? computer_req : player_req;
    assign pos_sel = turn ? computer_pos : player_pos;
    assign pos_ok  = cell_free(mask, pos_sel);
    assign accept  = (state == S_WAIT) && req_sel && pos_ok;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        end_result = 2'b00;
        case (state)
            S_IDLE, S_MATCH_OVER: if (start) state_next = S_CLEAR;
            S_CLEAR:              state_next = S_WAIT;
            S_WAIT: begin
                if (accept) begin
                    state_next = S_ISSUE;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    // The side that failed to move forfeits to the other.
                    state_next = S_ROUND_END;
                    end_result = turn ? 2'b01 : 2'b10;
                end
            end
            S_ISSUE:              state_next = S_SETTLE;
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    if (who == 2'b01 || who == 2'b10) begin
                        state_next = S_ROUND_END;
                        end_result = who;
                    end else if (move_count == 4'd9) begin
                        state_next = S_ROUND_END;
                        end_result = 2'b11;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_ROUND_END: begin
                if (player_score == TARGET || computer_score == TARGET) state_next = S_MATCH_OVER;
                else                                                    state_next = S_CLEAR;
            end
            default:              state_next = S_IDLE;
        endcase
    end

    always_comb begin
        player_ack   = 1'b0;
        player_err   = 1'b0;
        computer_ack = 1'b0;
        computer_err = 1'b0;
        if (state == S_WAIT) begin
            if (!turn && player_req) begin
                player_ack = pos_ok;
                player_err = !pos_ok;
            end
            if (turn && computer_req) begin
                computer_ack = pos_ok;
                computer_err = !pos_ok;
            end
        end
        play       = (state == S_ISSUE) && !turn;
        pc         = (state == S_ISSUE) && turn;
        core_clear = (state == S_CLEAR);
        round_done = (state == S_ROUND_END);
        match_over = (state == S_MATCH_OVER);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            round_starter     <= 1'b0;
            mask              <= '0;
            wait_cnt          <= '0;
            settle_cnt        <= '0;
            turn              <= 1'b0;
            move_count        <= '0;
            player_position   <= '0;
            computer_position <= '0;
            round_result      <= '0;
            player_score      <= '0;
            computer_score    <= '0;
        end else begin
            case (state)
                S_IDLE, S_MATCH_OVER: begin
                    if (start) begin
                        round_starter  <= first_pc;
                        player_score   <= '0;
                        computer_score <= '0;
                    end
                end
                S_CLEAR: begin
                    mask       <= '0;
                    move_count <= '0;
                    turn       <= round_starter;
                    wait_cnt   <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (accept) begin
                        mask <= mask | cell_bit(pos_sel);
                        if (turn) computer_position <= computer_pos;
                        else      player_position   <= player_pos;
                    end
                end
                S_ISSUE: begin
                    move_count <= move_count + 4'd1;
                    settle_cnt <= '0;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (state_next == S_WAIT) begin
                        turn     <= ~turn;
                        wait_cnt <= '0;
                    end
                end
                S_ROUND_END: round_starter <= ~round_starter;
                default: ;
            endcase
            // Result and score land together so they are valid alongside round_done.
            if (state_next == S_ROUND_END) begin
                round_result <= end_result;
                if (end_result == 2'b01) player_score   <= sat_inc(player_score);
                if (end_result == 2'b10) computer_score <= sat_inc(computer_score);
            end
        end
    end

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// Self-checking bench for ttt_turn_sequencer: directed scenarios plus random games scored
// by a board-level reference model that also plays the role of the core's win detector.
module tb_ttt_turn_sequencer;

    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 20;
    localparam int TARGET  = 3;
    localparam int SW      = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          first_pc = 1'b0;
    logic          player_req = 1'b0;
    logic [3:0]    player_pos = 4'd0;
    logic          computer_req = 1'b0;
    logic [3:0]    computer_pos = 4'd0;
    logic [1:0]    who = 2'b00;
    logic          player_ack, player_err, computer_ack, computer_err;
    logic          play, pc, core_clear, turn, round_done, match_over;
    logic [3:0]    player_position, computer_position, move_count;
    logic [1:0]    round_result;
    logic [SW-1:0] player_score, computer_score;

    ttt_turn_sequencer #(
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT), .WIN_TARGET(TARGET), .SCORE_W(SW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .first_pc(first_pc),
        .player_req(player_req), .player_pos(player_pos),
        .player_ack(player_ack), .player_err(player_err),
        .computer_req(computer_req), .computer_pos(computer_pos),
        .computer_ack(computer_ack), .computer_err(computer_err),
        .who(who), .play(play), .pc(pc),
        .player_position(player_position), .computer_position(computer_position),
        .core_clear(core_clear), .turn(turn), .move_count(move_count),
        .round_done(round_done), .round_result(round_result),
        .player_score(player_score), .computer_score(computer_score),
        .match_over(match_over)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model: occupied cells per side, scores, whose turn, who opens next round.
    bit [8:0] m_p, m_c;
    int       m_count, m_ps, m_cs;
    bit       m_turn, m_starter, m_ended;
    bit [1:0] m_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    function automatic bit has_line(input bit [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    function automatic bit cell_taken(input int pos);
        return (pos <= 8) && (m_p[pos] | m_c[pos]);
    endfunction

    task automatic round_finish(input bit [1:0] res);
        m_res = res;
        if (res == 2'b01 && m_ps < 15) m_ps++;
        if (res == 2'b10 && m_cs < 15) m_cs++;
        m_ended = 1'b1;
        chk("round_done", round_done, 1);
        chk("round_result", round_result, res);
        chk("player_score", player_score, m_ps);
        chk("computer_score", computer_score, m_cs);
        m_starter = !m_starter;
        step();
        chk("round_done_pulse", round_done, 0);
        if (m_ps == TARGET || m_cs == TARGET) begin
            chk("match_over", match_over, 1);
            chk("no_clear_at_match_end", core_clear, 0);
        end else begin
            chk("core_clear", core_clear, 1);
            chk("match_over_low", match_over, 0);
            step();
            m_turn = m_starter; m_p = '0; m_c = '0; m_count = 0;
            chk("core_clear_one_cycle", core_clear, 0);
            chk("new_round_turn", turn, m_turn);
            chk("new_round_count", move_count, 0);
        end
    endtask

    // Accepted move by the side to move; the bench decides the core's who from the board.
    task automatic move(input bit side, input int pos, input bit junk);
        bit [1:0] w;
        if (side) begin computer_req = 1'b1; computer_pos = 4'(pos); end
        else      begin player_req   = 1'b1; player_pos   = 4'(pos); end
        #1;
        chk("ack", side ? computer_ack : player_ack, 1);
        chk("no_err", {player_err, computer_err}, 0);
        chk("other_ack", side ? player_ack : computer_ack, 0);
        step();
        if (side) computer_req = 1'b0; else player_req = 1'b0;
        if (side) m_c[pos] = 1'b1; else m_p[pos] = 1'b1;
        m_count++;
        chk("strobe", {play, pc}, side ? 2'b01 : 2'b10);
        chk("position", side ? computer_position : player_position, pos);
        if (has_line(m_p))                   w = 2'b01;
        else if (has_line(m_c))              w = 2'b10;
        else if (junk && $urandom_range(1)) w = 2'b11;
        else                                 w = 2'b00;
        who = w;
        step();
        chk("strobe_one_cycle", {play, pc}, 0);
        repeat (SETTLE) step();
        who = junk ? 2'($urandom_range(3)) : 2'b00;
        chk("move_count", move_count, m_count);
        if (w == 2'b01)        round_finish(2'b01);
        else if (w == 2'b10)   round_finish(2'b10);
        else if (m_count == 9) round_finish(2'b11);
        else begin
            m_turn = !m_turn;
            chk("turn_toggle", turn, m_turn);
            chk("no_round_done", round_done, 0);
        end
    endtask

    task automatic bad(input bit side, input int pos, input int n);
        bit ok;
        ok = (pos <= 8) && !cell_taken(pos) && (side == m_turn);
        if (side) begin computer_req = 1'b1; computer_pos = 4'(pos); end
        else      begin player_req   = 1'b1; player_pos   = 4'(pos); end
        for (int i = 0; i < n; i++) begin
            #1;
            chk("bad_err", side ? computer_err : player_err, !ok);
            chk("bad_ack", side ? computer_ack : player_ack, 0);
            chk("bad_no_strobe", {play, pc}, 0);
            step();
        end
        if (side) computer_req = 1'b0; else player_req = 1'b0;
        chk("bad_count_same", move_count, m_count);
    endtask

    initial begin
        int n, pos, rounds;
        m_p = '0; m_c = '0; m_count = 0; m_ps = 0; m_cs = 0;
        m_turn = 0; m_starter = 0; m_res = 2'b00; m_ended = 0;

        repeat (3) step();
        chk("rst_pulses", {player_ack, player_err, computer_ack, computer_err, play, pc,
                           core_clear, round_done, match_over, turn}, 0);
        chk("rst_data", {player_position, computer_position, move_count, round_result,
                         player_score, computer_score}, 0);
        reset = 1'b1;
        step();
        chk("idle_stays", core_clear, 0);

        start = 1'b1; first_pc = 1'b0;
        step();
        start = 1'b0;
        chk("start_clear", core_clear, 1);
        chk("start_scores", {player_score, computer_score}, 0);
        step();
        chk("wait_turn", turn, 0);
        chk("wait_count", move_count, 0);
        chk("clear_one_cycle", core_clear, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ignored_clear", core_clear, 0);
        chk("start_ignored_turn", turn, 0);

        // Round 1: player takes the top row.
        move(0, 0, 0); move(1, 4, 0); move(0, 1, 0); move(1, 8, 0); move(0, 2, 0);

        // Round 2: computer opens; invalid and out-of-turn requests, then a timeout.
        move(1, 4, 0);
        bad(0, 4, 3);
        bad(0, 9, 2);
        computer_req = 1'b1; computer_pos = 4'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("out_of_turn_silent", {computer_ack, computer_err}, 0);
            step();
        end
        move(0, 8, 0);
        move(1, 0, 0);
        n = 0;
        while (!round_done && n < 100) begin step(); n++; end
        chk("timeout_len", n, TIMEOUT);
        round_finish(m_turn ? 2'b01 : 2'b10);

        // Round 3: full-board draw.
        move(0, 0, 0); move(1, 4, 0); move(0, 8, 0); move(1, 1, 0); move(0, 7, 0);
        move(1, 6, 0); move(0, 2, 0); move(1, 5, 0); move(0, 3, 0);

        // Random rounds until the match ends.
        rounds = 0;
        while (!(m_ps == TARGET || m_cs == TARGET) && rounds < 40) begin
            m_ended = 0;
            rounds++;
            while (!m_ended) begin
                if ($urandom_range(3) == 0) begin
                    if (m_count > 0 && $urandom_range(1)) begin
                        do pos = $urandom_range(8); while (!cell_taken(pos));
                    end else begin
                        pos = 9 + $urandom_range(6);
                    end
                    bad(m_turn, pos, 1 + $urandom_range(1));
                end
                do pos = $urandom_range(8); while (cell_taken(pos));
                move(m_turn, pos, 1);
            end
        end
        chk("match_reached", match_over, 1);
        repeat (2) step();
        chk("match_over_held", match_over, 1);
        chk("scores_held", {player_score, computer_score}, {m_ps[SW-1:0], m_cs[SW-1:0]});
        chk("result_held", round_result, m_res);

        // Restart from MATCH_OVER with the computer first, then reset during SETTLE.
        start = 1'b1; first_pc = 1'b1;
        step();
        start = 1'b0;
        chk("restart_clear", core_clear, 1);
        chk("restart_scores", {player_score, computer_score}, 0);
        chk("restart_result_held", round_result, m_res);
        step();
        chk("restart_turn", turn, 1);
        computer_req = 1'b1; computer_pos = 4'd3;
        #1;
        chk("restart_ack", computer_ack, 1);
        step();
        computer_req = 1'b0;
        chk("restart_pc", pc, 1);
        step();
        reset = 1'b0;
        #1;
        chk("abort_pulses", {player_ack, player_err, computer_ack, computer_err, play, pc,
                             core_clear, round_done, match_over, turn}, 0);
        chk("abort_data", {player_position, computer_position, move_count, round_result,
                           player_score, computer_score}, 0);
        step();
        reset = 1'b1;
        step();
        chk("post_abort_idle", {core_clear, match_over, turn, move_count}, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("post_abort_start", core_clear, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
